// File: rtl/cam_pkg.sv
// Shared state encoding, pin decode and default 50 MHz timing for the
// camera power/bring-up sequencer.
package cam_pkg;

   localparam int CAM_CNT_W = 24;

   // Default phase lengths in 50 MHz cycles.
   localparam int CAM_T_PWDN      = 50_000;
   localparam int CAM_T_RST       = 10_000;
   localparam int CAM_T_BOOT      = 1_000_000;
   localparam int CAM_CFG_TIMEOUT = 5_000_000;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PWDN_HOLD = 3'd1,
      ST_RST_HOLD  = 3'd2,
      ST_BOOT_WAIT = 3'd3,
      ST_CFG_REQ   = 3'd4,
      ST_CFG_WAIT  = 3'd5,
      ST_RUN       = 3'd6,
      ST_FAULT     = 3'd7
   } cam_state_e;

   typedef struct packed {
      logic pwdn;
      logic rst_n;
      logic cfg_start;
      logic csi_en;
      logic ready;
      logic fault;
   } cam_pins_t;

   // Pin levels owned by each state; the sensor stays powered and out of
   // reset from BOOT_WAIT through RUN.
   function automatic cam_pins_t cam_decode(input cam_state_e st);
      cam_pins_t p;
      p = '0;
      case (st)
         ST_IDLE:      p.pwdn = 1'b1;
         ST_PWDN_HOLD: p.pwdn = 1'b1;
         ST_RST_HOLD:  p.pwdn = 1'b0;
         ST_BOOT_WAIT: p.rst_n = 1'b1;
         ST_CFG_REQ: begin
            p.rst_n     = 1'b1;
            p.cfg_start = 1'b1;
         end
         ST_CFG_WAIT:  p.rst_n = 1'b1;
         ST_RUN: begin
            p.rst_n  = 1'b1;
            p.csi_en = 1'b1;
            p.ready  = 1'b1;
         end
         ST_FAULT: begin
            p.pwdn  = 1'b1;
            p.fault = 1'b1;
         end
         default:      p.pwdn = 1'b1;
      endcase
      return p;
   endfunction

   // Terminal count for a phase lasting t cycles (counter starts at 0).
   function automatic logic [CAM_CNT_W-1:0] cam_term(input int t);
      return CAM_CNT_W'(t - 1);
   endfunction

endpackage

// File: rtl/cam_seq_timer.sv
// Loadable up-counter with synchronous clear and a terminal-count flag,
// used to time every phase of the camera sequencer.
module cam_seq_timer
   import cam_pkg::*;
#(
   parameter int CNT_W = CAM_CNT_W
) (
   input  logic             clk_50m,
   input  logic             rst,
   input  logic             clr,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic [CNT_W-1:0] term,
   output logic             tc
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk_50m) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign tc = (cnt == term);

endmodule

// File: rtl/cam_power_seq.sv
// Camera sensor power-up sequencer: timed pwdn/reset release, SCCB config
// handshake with bounded retries, CSI-2 enable once configuration succeeds.
module cam_power_seq
   import cam_pkg::*;
#(
   parameter int T_PWDN      = CAM_T_PWDN,
   parameter int T_RST       = CAM_T_RST,
   parameter int T_BOOT      = CAM_T_BOOT,
   parameter int CFG_TIMEOUT = CAM_CFG_TIMEOUT,
   parameter int MAX_RETRY   = 3
) (
   input  logic       clk_50m,
   input  logic       rst,
   input  logic       enable,
   input  logic       restart,
   output logic       cam_pwdn,
   output logic       cam_rst,
   output logic       cfg_start,
   input  logic       cfg_done,
   input  logic       cfg_err,
   output logic       csi_en,
   output logic       ready,
   output logic       fault,
   output logic [1:0] retry_cnt,
   output logic [2:0] state
);

   // retry_cnt is 2 bits wide, so MAX_RETRY is meaningful in 1..3.
   localparam logic [1:0] RETRY_LIM = 2'(MAX_RETRY);

   cam_state_e           cur_st;
   cam_state_e           nxt_st;
   logic [1:0]           retry_nxt;
   logic [CAM_CNT_W-1:0] term;
   logic                 tc;
   logic                 tmr_clr;
   cam_pins_t            pins;

   always_comb begin
      term = '1;
      case (cur_st)
         ST_PWDN_HOLD: term = cam_term(T_PWDN);
         ST_RST_HOLD:  term = cam_term(T_RST);
         ST_BOOT_WAIT: term = cam_term(T_BOOT);
         ST_CFG_WAIT:  term = cam_term(CFG_TIMEOUT);
         default:      term = '1;
      endcase
   end

   cam_seq_timer #(
      .CNT_W (CAM_CNT_W)
   ) u_timer (
      .clk_50m  (clk_50m),
      .rst      (rst),
      .clr      (tmr_clr),
      .load     (1'b0),
      .load_val ('0),
      .term     (term),
      .tc       (tc)
   );

   always_comb begin
      nxt_st    = cur_st;
      retry_nxt = retry_cnt;
      if (!enable) begin
         nxt_st = ST_IDLE;
      end else begin
         case (cur_st)
            ST_IDLE: begin
               nxt_st    = ST_PWDN_HOLD;
               retry_nxt = 2'd0;
            end
            ST_PWDN_HOLD: if (tc) nxt_st = ST_RST_HOLD;
            ST_RST_HOLD:  if (tc) nxt_st = ST_BOOT_WAIT;
            ST_BOOT_WAIT: if (tc) nxt_st = ST_CFG_REQ;
            ST_CFG_REQ: begin
               nxt_st    = ST_CFG_WAIT;
               retry_nxt = retry_cnt + 2'd1;
            end
            ST_CFG_WAIT: begin
               // Error beats done; done on the last timeout cycle still wins.
               if (cfg_err || (tc && !cfg_done)) begin
                  nxt_st = (retry_cnt < RETRY_LIM) ? ST_PWDN_HOLD : ST_FAULT;
               end else if (cfg_done) begin
                  nxt_st = ST_RUN;
               end
            end
            ST_RUN, ST_FAULT: begin
               if (restart) begin
                  nxt_st    = ST_PWDN_HOLD;
                  retry_nxt = 2'd0;
               end
            end
            default: nxt_st = ST_IDLE;
         endcase
      end
      // Counter restarts on every state entry and idles at zero in untimed states.
      tmr_clr = (nxt_st != cur_st) || (cur_st == ST_IDLE) || (cur_st == ST_CFG_REQ) ||
                (cur_st == ST_RUN) || (cur_st == ST_FAULT);
   end

   always_ff @(posedge clk_50m) begin
      if (rst) begin
         cur_st    <= ST_IDLE;
         retry_cnt <= 2'd0;
      end else begin
         cur_st    <= nxt_st;
         retry_cnt <= retry_nxt;
      end
   end

   assign pins  = cam_decode(cur_st);
   assign state = cur_st;

   // Pins are registered from the registered state: one cycle behind state.
   always_ff @(posedge clk_50m) begin
      if (rst) begin
         cam_pwdn  <= 1'b1;
         cam_rst   <= 1'b0;
         cfg_start <= 1'b0;
         csi_en    <= 1'b0;
         ready     <= 1'b0;
         fault     <= 1'b0;
      end else begin
         cam_pwdn  <= pins.pwdn;
         cam_rst   <= pins.rst_n;
         cfg_start <= pins.cfg_start;
         csi_en    <= pins.csi_en;
         ready     <= pins.ready;
         fault     <= pins.fault;
      end
   end

endmodule
